// File: rtl/demux_stream_pkg.sv
// Shared defaults, select-width helper and slot state type for the stream router.
package demux_stream_pkg;

   localparam int unsigned DEF_DW    = 8;
   localparam int unsigned DEF_NCH   = 4;
   localparam int unsigned DEF_CNT_W = 8;

   // Select width for a given channel count, never narrower than one bit.
   function automatic int unsigned sel_width(input int unsigned nch);
      return (nch <= 2) ? 1 : $clog2(nch);
   endfunction

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/demux_stream_router_if.sv
// Stream bus between one producer, the router and NCH consumers.
interface demux_stream_router_if #(
   parameter int unsigned DW    = 8,
   parameter int unsigned NCH   = 4,
   parameter int unsigned SEL_W = 2
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_data;
   logic [SEL_W-1:0]  in_sel;
   logic              in_bcast;
   logic [NCH-1:0]    out_valid;
   logic [NCH-1:0]    out_ready;
   logic [NCH*DW-1:0] out_data;

   // Environment side: producer and consumers.
   modport master (
      output in_valid, in_data, in_sel, in_bcast, out_ready,
      input  in_ready, out_valid, out_data
   );

   // Router side.
   modport slave (
      input  in_valid, in_data, in_sel, in_bcast, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/demux_out_slot.sv
// One-entry registered holding slot for a single output channel.
module demux_out_slot
   import demux_stream_pkg::*;
#(
   parameter int unsigned DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          free
);

   slot_state_e   state_q;
   logic [DW-1:0] data_q;

   // Load wins over drain, so a simultaneous drain+load keeps the slot FULL with new data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
      end else if (load) begin
         state_q <= FULL;
         data_q  <= load_data;
      end else if (state_q == FULL && out_ready) begin
         state_q <= EMPTY;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = data_q;
   assign free      = (state_q == EMPTY) | out_ready;

endmodule

// File: rtl/demux_stream_router.sv
// Routes one valid/ready stream to one of NCH channels or to all of them.
module demux_stream_router
   import demux_stream_pkg::*;
#(
   parameter int unsigned DW    = DEF_DW,
   parameter int unsigned NCH   = DEF_NCH,
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned SEL_W = sel_width(NCH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   demux_stream_router_if.slave bus,
   output logic [CNT_W-1:0]     drop_cnt
);

   logic [NCH-1:0]   free;
   logic [NCH-1:0]   load;
   logic             sel_ok;
   logic             free_sel;
   logic             in_ready_c;
   logic             accept;
   logic [CNT_W-1:0] drop_q;
   logic [CNT_W-1:0] drop_d;

   // Select decode, acceptance, per-slot load strobes and drop counter next value.
   always_comb begin
      sel_ok   = 1'b0;
      free_sel = 1'b0;
      load     = '0;
      drop_d   = drop_q;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (bus.in_sel == SEL_W'(i)) begin
            sel_ok   = 1'b1;
            free_sel = free[i];
         end
      end
      if (bus.in_bcast) begin
         in_ready_c = &free;
      end else if (sel_ok) begin
         in_ready_c = free_sel;
      end else begin
         in_ready_c = 1'b1;
      end
      accept = bus.in_valid & in_ready_c;
      for (int unsigned i = 0; i < NCH; i++) begin
         load[i] = accept & (bus.in_bcast | (bus.in_sel == SEL_W'(i)));
      end
      if (accept && !bus.in_bcast && !sel_ok && drop_q != {CNT_W{1'b1}}) begin
         drop_d = drop_q + CNT_W'(1);
      end
   end

   // Saturating count of out-of-range words.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign bus.in_ready = in_ready_c;
   assign drop_cnt     = drop_q;

   for (genvar g = 0; g < NCH; g++) begin : g_slot
      demux_out_slot #(.DW(DW)) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (load[g]),
         .load_data (bus.in_data),
         .out_ready (bus.out_ready[g]),
         .out_valid (bus.out_valid[g]),
         .out_data  (bus.out_data[g*DW +: DW]),
         .free      (free[g])
      );
   end

endmodule

// File: tb/tb_demux_stream_router.sv
// Randomized and directed checks of the stream router against a channel-level model.
module tb_demux_stream_router;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] drop4;
   logic [7:0] drop3;
   int         total = 0;
   int         bad   = 0;

   // Model of the NCH=4 instance: per-channel occupancy, held word and drop count.
   bit         mv [4];
   logic [7:0] md [4];
   int         mdrop;

   demux_stream_router_if #(.DW(8), .NCH(4), .SEL_W(2)) bus4 ();
   demux_stream_router_if #(.DW(8), .NCH(3), .SEL_W(2)) bus3 ();

   demux_stream_router #(.DW(8), .NCH(4), .CNT_W(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .drop_cnt(drop4));
   demux_stream_router #(.DW(8), .NCH(3), .CNT_W(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3.slave), .drop_cnt(drop3));

   always #5 clk = ~clk;

   function automatic bit model_ready();
      bit all_free = 1'b1;
      for (int i = 0; i < 4; i++) all_free &= (!mv[i] || bus4.out_ready[i]);
      if (bus4.in_bcast) return all_free;
      return !mv[bus4.in_sel] || bus4.out_ready[bus4.in_sel];
   endfunction

   function automatic logic [3:0] model_valid();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = mv[i];
      return v;
   endfunction

   function automatic logic [31:0] model_data();
      logic [31:0] d;
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = md[i];
      return d;
   endfunction

   // Advance the model by one clock edge using the inputs presented before it.
   task automatic model_clock();
      bit acc;
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin mv[i] = 1'b0; md[i] = 8'h00; end
         mdrop = 0;
      end else begin
         acc = bus4.in_valid && model_ready();
         for (int i = 0; i < 4; i++) begin
            if (acc && (bus4.in_bcast || bus4.in_sel == 2'(i))) begin
               mv[i] = 1'b1;
               md[i] = bus4.in_data;
            end else if (bus4.out_ready[i]) begin
               mv[i] = 1'b0;
            end
         end
      end
   endtask

   // Rising edge, model update, then back to the falling edge where inputs change.
   task automatic tick();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus4.in_valid = 1'b0; bus4.in_data = 8'h00; bus4.in_sel = 2'd0; bus4.in_bcast = 1'b0;
      bus4.out_ready = 4'hF;
      bus3.in_valid = 1'b0; bus3.in_data = 8'h00; bus3.in_sel = 2'd0; bus3.in_bcast = 1'b0;
      bus3.out_ready = 3'h7;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      bus4.in_valid = 1'b1; bus4.in_data = 8'hAA; bus4.out_ready = 4'h0;
      bus3.in_valid = 1'b1; bus3.in_data = 8'hAA; bus3.out_ready = 3'h0;
      @(negedge clk);
      tick();
      tick();
      total++; if (bus4.out_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid4 got=%b exp=0000", bus4.out_valid); end
      total++; if (bus4.out_data !== 32'h0) begin bad++; $display("FAIL reset_data4 got=%h exp=0", bus4.out_data); end
      total++; if (drop4 !== 8'd0) begin bad++; $display("FAIL reset_drop4 got=%0d exp=0", drop4); end
      total++; if (bus3.out_valid !== 3'b000) begin bad++; $display("FAIL reset_valid3 got=%b exp=000", bus3.out_valid); end
      total++; if (drop3 !== 8'd0) begin bad++; $display("FAIL reset_drop3 got=%0d exp=0", drop3); end
      rst_n = 1'b1;
      idle_inputs();
      tick();
   endtask

   task automatic test_unicast();
      bus4.out_ready = 4'hF;
      for (int i = 0; i < 4; i++) begin
         bus4.in_valid = 1'b1; bus4.in_sel = 2'(i); bus4.in_data = 8'h10 + 8'(i);
         #1;
         total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL uni_ready ch%0d got=%b exp=1", i, bus4.in_ready); end
         tick();
         total++; if (bus4.out_valid !== 4'(1 << i)) begin bad++; $display("FAIL uni_valid ch%0d got=%b exp=%b", i, bus4.out_valid, 4'(1 << i)); end
         total++; if (bus4.out_data[i*8 +: 8] !== 8'h10 + 8'(i)) begin bad++; $display("FAIL uni_data ch%0d got=%h exp=%h", i, bus4.out_data[i*8 +: 8], 8'h10 + 8'(i)); end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_backpressure();
      bus4.out_ready = 4'b1011;
      bus4.in_valid = 1'b1; bus4.in_sel = 2'd2; bus4.in_data = 8'h55;
      #1;
      total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL bp_first_ready got=%b exp=1", bus4.in_ready); end
      tick();
      bus4.in_data = 8'h66;
      #1;
      total++; if (bus4.in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_ready got=%b exp=0", bus4.in_ready); end
      total++; if (bus4.out_data[23:16] !== 8'h55 || bus4.out_valid[2] !== 1'b1) begin bad++; $display("FAIL bp_hold got=%h/%b exp=55/1", bus4.out_data[23:16], bus4.out_valid[2]); end
      tick();
      total++; if (bus4.out_data[23:16] !== 8'h55 || bus4.out_valid[2] !== 1'b1) begin bad++; $display("FAIL bp_hold2 got=%h/%b exp=55/1", bus4.out_data[23:16], bus4.out_valid[2]); end
      bus4.in_sel = 2'd1; bus4.in_data = 8'h77;
      #1;
      total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL bp_other_ready got=%b exp=1", bus4.in_ready); end
      tick();
      total++; if (bus4.out_valid[1] !== 1'b1 || bus4.out_data[15:8] !== 8'h77) begin bad++; $display("FAIL bp_other_data got=%h/%b exp=77/1", bus4.out_data[15:8], bus4.out_valid[1]); end
      bus4.in_sel = 2'd2; bus4.in_data = 8'h66; bus4.out_ready = 4'hF;
      #1;
      total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", bus4.in_ready); end
      tick();
      total++; if (bus4.out_valid[2] !== 1'b1 || bus4.out_data[23:16] !== 8'h66) begin bad++; $display("FAIL bp_release_data got=%h/%b exp=66/1", bus4.out_data[23:16], bus4.out_valid[2]); end
      idle_inputs();
      tick();
   endtask

   task automatic test_broadcast();
      bus4.in_valid = 1'b1; bus4.in_bcast = 1'b1; bus4.in_sel = 2'd1; bus4.in_data = 8'hC3;
      #1;
      total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL bc_ready got=%b exp=1", bus4.in_ready); end
      tick();
      total++; if (bus4.out_valid !== 4'hF || bus4.out_data !== {4{8'hC3}}) begin bad++; $display("FAIL bc_data got=%h/%b exp=c3c3c3c3/1111", bus4.out_data, bus4.out_valid); end
      bus4.in_valid = 1'b0; bus4.out_ready = 4'b0111;
      tick();
      bus4.in_valid = 1'b1; bus4.in_data = 8'h5A;
      #1;
      total++; if (bus4.in_ready !== 1'b0) begin bad++; $display("FAIL bc_blocked got=%b exp=0", bus4.in_ready); end
      tick();
      total++; if (bus4.out_valid !== 4'b1000 || bus4.out_data[31:24] !== 8'hC3) begin bad++; $display("FAIL bc_hold got=%h/%b exp=c3/1000", bus4.out_data[31:24], bus4.out_valid); end
      bus4.out_ready = 4'hF;
      #1;
      total++; if (bus4.in_ready !== 1'b1) begin bad++; $display("FAIL bc_drained_ready got=%b exp=1", bus4.in_ready); end
      tick();
      total++; if (bus4.out_valid !== 4'hF || bus4.out_data !== {4{8'h5A}}) begin bad++; $display("FAIL bc_second got=%h/%b exp=5a5a5a5a/1111", bus4.out_data, bus4.out_valid); end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      bus3.out_ready = 3'b000;
      bus3.in_valid = 1'b1; bus3.in_sel = 2'd3;
      for (int k = 0; k < 5; k++) tick();
      bus3.in_sel = 2'd0; bus3.in_data = 8'h21;
      tick();
      bus3.in_valid = 1'b0;
      total++; if (drop3 !== 8'd5) begin bad++; $display("FAIL mid_drop_pre got=%0d exp=5", drop3); end
      total++; if (bus3.out_valid !== 3'b001 || bus3.out_data[7:0] !== 8'h21) begin bad++; $display("FAIL mid_slot_pre got=%h/%b exp=21/001", bus3.out_data[7:0], bus3.out_valid); end
      rst_n = 1'b0;
      tick();
      total++; if (bus3.out_valid !== 3'b000) begin bad++; $display("FAIL mid_valid got=%b exp=000", bus3.out_valid); end
      total++; if (drop3 !== 8'd0) begin bad++; $display("FAIL mid_drop got=%0d exp=0", drop3); end
      rst_n = 1'b1;
      idle_inputs();
      tick();
   endtask

   task automatic test_drop();
      int exp_cnt;
      bus3.out_ready = 3'b000;
      bus3.in_valid = 1'b1; bus3.in_sel = 2'd3; bus3.in_bcast = 1'b0;
      for (int k = 0; k < 300; k++) begin
         bus3.in_data = 8'($urandom);
         #1;
         total++; if (bus3.in_ready !== 1'b1) begin bad++; $display("FAIL drop_ready cyc%0d got=%b exp=1", k, bus3.in_ready); end
         tick();
         exp_cnt = (k + 1 > 255) ? 255 : k + 1;
         total++; if (bus3.out_valid !== 3'b000) begin bad++; $display("FAIL drop_valid cyc%0d got=%b exp=000", k, bus3.out_valid); end
         total++; if (drop3 !== 8'(exp_cnt)) begin bad++; $display("FAIL drop_cnt cyc%0d got=%0d exp=%0d", k, drop3, exp_cnt); end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_random();
      bit exp_rdy;
      for (int k = 0; k < 500; k++) begin
         bus4.in_valid  = ($urandom_range(3) != 0);
         bus4.in_bcast  = ($urandom_range(7) == 0);
         bus4.in_sel    = 2'($urandom_range(3));
         bus4.in_data   = 8'($urandom);
         bus4.out_ready = 4'($urandom) | 4'($urandom);
         #1;
         exp_rdy = model_ready();
         total++; if (bus4.in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready cyc%0d got=%b exp=%b", k, bus4.in_ready, exp_rdy); end
         tick();
         total++; if (bus4.out_valid !== model_valid()) begin bad++; $display("FAIL rnd_valid cyc%0d got=%b exp=%b", k, bus4.out_valid, model_valid()); end
         total++; if (bus4.out_data !== model_data()) begin bad++; $display("FAIL rnd_data cyc%0d got=%h exp=%h", k, bus4.out_data, model_data()); end
         total++; if (drop4 !== 8'(mdrop)) begin bad++; $display("FAIL rnd_drop cyc%0d got=%0d exp=%0d", k, drop4, mdrop); end
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      mdrop = 0;
      for (int i = 0; i < 4; i++) begin mv[i] = 1'b0; md[i] = 8'h00; end
      test_reset();
      test_unicast();
      test_backpressure();
      test_broadcast();
      test_reset_mid();
      test_drop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
